// File: rtl/ddr2_rd_data_checker.sv
// DDR2 read-data checker: compares returned read beats against the generator's
// expected pattern lane by lane and keeps error status, counters and a first-failure capture.
module ddr2_rd_data_checker #(
   parameter int DQ_WIDTH        = 32,
   parameter int BEATS_PER_BURST = 2
) (
   input  logic                      clk0,
   input  logic                      rst,
   input  logic                      rd_data_valid,
   input  logic [2*DQ_WIDTH-1:0]     rd_data,
   input  logic [2*DQ_WIDTH-1:0]     cmp_data,
   input  logic [2*DQ_WIDTH/8-1:0]   cmp_mask,
   input  logic                      clr_err,
   output logic                      cmp_error,
   output logic                      err_sticky,
   output logic [2*DQ_WIDTH/8-1:0]   err_lane_mask,
   output logic [15:0]               err_count,
   output logic [15:0]               burst_count,
   output logic [15:0]               first_err_beat,
   output logic [2*DQ_WIDTH-1:0]     first_err_actual,
   output logic [2*DQ_WIDTH-1:0]     first_err_expected,
   output logic [1:0]                chk_state
);

   localparam int BW  = 2 * DQ_WIDTH;
   localparam int NB  = BW / 8;
   localparam int IBW = (BEATS_PER_BURST > 1) ? $clog2(BEATS_PER_BURST) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FAIL = 2'b10
   } state_e;

   // Stage 1: registered inputs
   logic           s1_valid_q;
   logic [BW-1:0]  s1_data_q;
   logic [BW-1:0]  s1_exp_q;
   logic [NB-1:0]  s1_mask_q;

   // Beat bookkeeping, advanced by stage-1 valid beats
   logic [15:0]    beat_cnt_q;
   logic [IBW-1:0] inburst_q;
   logic           last_beat;

   // Stage 2: per-lane compare result plus the beat context needed for captures
   logic [NB-1:0]  lane_err;
   logic           s2_valid_q;
   logic [NB-1:0]  s2_lane_err_q;
   logic [BW-1:0]  s2_data_q;
   logic [BW-1:0]  s2_exp_q;
   logic [15:0]    s2_beat_q;
   logic           s2_last_q;

   // Status stage
   logic           err_any;
   logic           cmp_error_q,   cmp_error_d;
   logic           err_sticky_q,  err_sticky_d;
   logic [NB-1:0]  err_lane_q,    err_lane_d;
   logic [15:0]    err_count_q,   err_count_d;
   logic [15:0]    burst_count_q, burst_count_d;
   logic [15:0]    first_beat_q,  first_beat_d;
   logic [BW-1:0]  first_act_q,   first_act_d;
   logic [BW-1:0]  first_exp_q,   first_exp_d;
   state_e         state_q,       state_d;

   // NOTE: every clocked block uses non-blocking assignments so all registers
   // sample pre-edge values and the pipeline stages do not collapse into one.
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_exp_q   <= '0;
         s1_mask_q  <= '0;
      end else if (clr_err) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_exp_q   <= '0;
         s1_mask_q  <= '0;
      end else begin
         s1_valid_q <= rd_data_valid;
         s1_data_q  <= rd_data;
         s1_exp_q   <= cmp_data;
         s1_mask_q  <= cmp_mask;
      end
   end

   assign last_beat = (inburst_q == IBW'(BEATS_PER_BURST - 1));

   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         beat_cnt_q <= '0;
         inburst_q  <= '0;
      end else if (clr_err) begin
         beat_cnt_q <= '0;
         inburst_q  <= '0;
      end else if (s1_valid_q) begin
         beat_cnt_q <= beat_cnt_q + 16'd1;
         inburst_q  <= last_beat ? '0 : inburst_q + IBW'(1);
      end
   end

   // NOTE: combinational blocks assign a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      lane_err = '0;
      for (int i = 0; i < NB; i++) begin
         lane_err[i] = s1_valid_q && !s1_mask_q[i] &&
                       (s1_data_q[8*i +: 8] != s1_exp_q[8*i +: 8]);
      end
   end

   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         s2_valid_q    <= 1'b0;
         s2_lane_err_q <= '0;
         s2_data_q     <= '0;
         s2_exp_q      <= '0;
         s2_beat_q     <= '0;
         s2_last_q     <= 1'b0;
      end else if (clr_err) begin
         s2_valid_q    <= 1'b0;
         s2_lane_err_q <= '0;
         s2_data_q     <= '0;
         s2_exp_q      <= '0;
         s2_beat_q     <= '0;
         s2_last_q     <= 1'b0;
      end else begin
         s2_valid_q    <= s1_valid_q;
         s2_lane_err_q <= lane_err;
         s2_data_q     <= s1_data_q;
         s2_exp_q      <= s1_exp_q;
         s2_beat_q     <= beat_cnt_q;
         s2_last_q     <= s1_valid_q && last_beat;
      end
   end

   assign err_any = s2_valid_q && (|s2_lane_err_q);

   always_comb begin
      cmp_error_d   = 1'b0;
      err_sticky_d  = err_sticky_q;
      err_lane_d    = err_lane_q;
      err_count_d   = err_count_q;
      burst_count_d = burst_count_q;
      first_beat_d  = first_beat_q;
      first_act_d   = first_act_q;
      first_exp_d   = first_exp_q;
      if (s2_valid_q && s2_last_q) begin
         burst_count_d = burst_count_q + 16'd1;
      end
      if (err_any) begin
         cmp_error_d  = 1'b1;
         err_sticky_d = 1'b1;
         err_lane_d   = err_lane_q | s2_lane_err_q;
         if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
         end
         // Only the first failure since reset/clear is captured
         if (!err_sticky_q) begin
            first_beat_d = s2_beat_q;
            first_act_d  = s2_data_q;
            first_exp_d  = s2_exp_q;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (err_any)         state_d = ST_FAIL;
            else if (s2_valid_q) state_d = ST_RUN;
         end
         ST_RUN:  if (err_any) state_d = ST_FAIL;
         ST_FAIL: state_d = ST_FAIL;
         default: state_d = ST_IDLE;
      endcase
      if (clr_err) state_d = ST_IDLE;
   end

   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear wins over a mismatch arriving in the same cycle
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         cmp_error_q   <= 1'b0;
         err_sticky_q  <= 1'b0;
         err_lane_q    <= '0;
         err_count_q   <= '0;
         burst_count_q <= '0;
         first_beat_q  <= '0;
         first_act_q   <= '0;
         first_exp_q   <= '0;
      end else if (clr_err) begin
         cmp_error_q   <= 1'b0;
         err_sticky_q  <= 1'b0;
         err_lane_q    <= '0;
         err_count_q   <= '0;
         burst_count_q <= '0;
         first_beat_q  <= '0;
         first_act_q   <= '0;
         first_exp_q   <= '0;
      end else begin
         cmp_error_q   <= cmp_error_d;
         err_sticky_q  <= err_sticky_d;
         err_lane_q    <= err_lane_d;
         err_count_q   <= err_count_d;
         burst_count_q <= burst_count_d;
         first_beat_q  <= first_beat_d;
         first_act_q   <= first_act_d;
         first_exp_q   <= first_exp_d;
      end
   end

   assign cmp_error          = cmp_error_q;
   assign err_sticky         = err_sticky_q;
   assign err_lane_mask      = err_lane_q;
   assign err_count          = err_count_q;
   assign burst_count        = burst_count_q;
   assign first_err_beat     = first_beat_q;
   assign first_err_actual   = first_act_q;
   assign first_err_expected = first_exp_q;
   assign chk_state          = state_q;

endmodule

// File: tb/tb_ddr2_rd_data_checker.sv
// Scoreboard bench for ddr2_rd_data_checker: the driver queues the expected status
// for each beat, and a negedge monitor compares it when that beat's result is due.
module tb_ddr2_rd_data_checker;

   localparam int DQ  = 32;
   localparam int BW  = 2 * DQ;
   localparam int NB  = BW / 8;
   localparam int BPB = 2;

   typedef struct packed {
      logic        err;
      logic [15:0] ecnt;
      logic [15:0] bcnt;
      logic [1:0]  st;
      logic [7:0]  lanes;
      logic [15:0] first;
   } rec_t;

   typedef struct {
      rec_t        r;
      int unsigned due;
   } item_t;

   logic          clk0 = 1'b0;
   logic          rst;
   logic          rd_data_valid;
   logic [BW-1:0] rd_data;
   logic [BW-1:0] cmp_data;
   logic [NB-1:0] cmp_mask;
   logic          clr_err;
   logic          cmp_error;
   logic          err_sticky;
   logic [NB-1:0] err_lane_mask;
   logic [15:0]   err_count;
   logic [15:0]   burst_count;
   logic [15:0]   first_err_beat;
   logic [BW-1:0] first_err_actual;
   logic [BW-1:0] first_err_expected;
   logic [1:0]    chk_state;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   item_t       exp_q[$];
   item_t       mon_it;
   rec_t        mon_act;

   // Bench-side expectation state
   logic [15:0] m_beat, m_ecnt, m_burst, m_first;
   logic [7:0]  m_lanes;
   logic [1:0]  m_state;
   logic        m_sticky;
   int          m_inb;

   ddr2_rd_data_checker #(.DQ_WIDTH(DQ), .BEATS_PER_BURST(BPB)) dut (
      .clk0               (clk0),
      .rst                (rst),
      .rd_data_valid      (rd_data_valid),
      .rd_data            (rd_data),
      .cmp_data           (cmp_data),
      .cmp_mask           (cmp_mask),
      .clr_err            (clr_err),
      .cmp_error          (cmp_error),
      .err_sticky         (err_sticky),
      .err_lane_mask      (err_lane_mask),
      .err_count          (err_count),
      .burst_count        (burst_count),
      .first_err_beat     (first_err_beat),
      .first_err_actual   (first_err_actual),
      .first_err_expected (first_err_expected),
      .chk_state          (chk_state)
   );

   always #5 clk0 = ~clk0;

   always @(posedge clk0) cyc <= cyc + 1;

   always @(negedge clk0) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         mon_it        = exp_q.pop_front();
         mon_act.err   = cmp_error;
         mon_act.ecnt  = err_count;
         mon_act.bcnt  = burst_count;
         mon_act.st    = chk_state;
         mon_act.lanes = err_lane_mask;
         mon_act.first = first_err_beat;
         checks++;
         if (mon_act !== mon_it.r) begin
            errors++;
            $display("FAIL beat_status @cyc %0d: got err/cnt/burst/st/lanes/first=%b/%h/%h/%b/%h/%h expected %b/%h/%h/%b/%h/%h",
                     cyc, mon_act.err, mon_act.ecnt, mon_act.bcnt, mon_act.st, mon_act.lanes, mon_act.first,
                     mon_it.r.err, mon_it.r.ecnt, mon_it.r.bcnt, mon_it.r.st, mon_it.r.lanes, mon_it.r.first);
         end
      end else if (cmp_error === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL spurious_cmp_error @cyc %0d: got 1 expected 0", cyc);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_beat = '0; m_ecnt = '0; m_burst = '0; m_first = '0;
      m_lanes = '0; m_state = 2'b00; m_sticky = 1'b0; m_inb = 0;
   endtask

   // bad = lanes that must be reported failing for this beat (hand-computed)
   task automatic send(input logic [63:0] d, input logic [63:0] e, input logic [7:0] m,
                       input logic [7:0] bad);
      item_t it;
      @(negedge clk0);
      rd_data_valid = 1'b1; rd_data = d; cmp_data = e; cmp_mask = m; clr_err = 1'b0;
      if (bad != 8'h00) begin
         if (!m_sticky) m_first = m_beat;
         if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
         m_lanes  = m_lanes | bad;
         m_sticky = 1'b1;
         m_state  = 2'b10;
      end else if (m_state == 2'b00) begin
         m_state = 2'b01;
      end
      m_inb = (m_inb + 1) % BPB;
      if (m_inb == 0) m_burst = m_burst + 16'd1;
      m_beat = m_beat + 16'd1;
      it.r.err   = (bad != 8'h00);
      it.r.ecnt  = m_ecnt;
      it.r.bcnt  = m_burst;
      it.r.st    = m_state;
      it.r.lanes = m_lanes;
      it.r.first = m_first;
      it.due     = cyc + 3;
      exp_q.push_back(it);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk0);
         rd_data_valid = 1'b0; clr_err = 1'b0;
      end
   endtask

   task automatic do_clear();
      idle(4);
      @(negedge clk0);
      clr_err = 1'b1; rd_data_valid = 1'b0;
      @(negedge clk0);
      clr_err = 1'b0;
      model_reset();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cmp_error"}, 64'(cmp_error), 64'd0);
      check({tag, "_sticky"},    64'(err_sticky), 64'd0);
      check({tag, "_lanes"},     64'(err_lane_mask), 64'd0);
      check({tag, "_err_count"}, 64'(err_count), 64'd0);
      check({tag, "_bursts"},    64'(burst_count), 64'd0);
      check({tag, "_first"},     64'(first_err_beat), 64'd0);
      check({tag, "_f_act"},     first_err_actual, 64'd0);
      check({tag, "_f_exp"},     first_err_expected, 64'd0);
      check({tag, "_state"},     64'(chk_state), 64'd0);
   endtask

   function automatic logic [63:0] pat(input int i);
      return 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0101_0101_0101_0101;
   endfunction

   logic [63:0] e5, e2, d2;

   initial begin
      rst = 1'b1; rd_data_valid = 1'b0; rd_data = '0; cmp_data = '0;
      cmp_mask = '0; clr_err = 1'b0;
      model_reset();
      repeat (3) @(negedge clk0);
      rst = 1'b0;
      @(negedge clk0);
      check_all_zero("reset");

      // Clean run: 8 matching beats -> 4 bursts, RUN
      for (int i = 0; i < 8; i++) send(pat(i), pat(i), 8'h00, 8'h00);
      idle(4);
      check("clean_bursts", 64'(burst_count), 64'd4);
      check("clean_state",  64'(chk_state), 64'd1);

      // Single error on beat 5, lane 3
      do_clear();
      e5 = pat(5);
      for (int i = 0; i < 8; i++) begin
         if (i == 5) send(pat(i) ^ 64'h0000_0000_FF00_0000, pat(i), 8'h00, 8'h08);
         else        send(pat(i), pat(i), 8'h00, 8'h00);
      end
      idle(4);
      check("single_count", 64'(err_count), 64'd1);
      check("single_lanes", 64'(err_lane_mask), 64'h08);
      check("single_first", 64'(first_err_beat), 64'd5);
      check("single_state", 64'(chk_state), 64'd2);
      check("single_f_act", first_err_actual, e5 ^ 64'h0000_0000_FF00_0000);
      check("single_f_exp", first_err_expected, e5);

      // First-error capture: beats 2 (lane 0) and 6 (lane 7)
      do_clear();
      e2 = pat(2);
      d2 = e2 ^ 64'h0000_0000_0000_00FF;
      for (int i = 0; i < 8; i++) begin
         if (i == 2)      send(d2, pat(i), 8'h00, 8'h01);
         else if (i == 6) send(pat(i) ^ 64'hFF00_0000_0000_0000, pat(i), 8'h00, 8'h80);
         else             send(pat(i), pat(i), 8'h00, 8'h00);
      end
      idle(4);
      check("first_count", 64'(err_count), 64'd2);
      check("first_lanes", 64'(err_lane_mask), 64'h81);
      check("first_beat",  64'(first_err_beat), 64'd2);
      check("first_f_act", first_err_actual, d2);
      check("first_f_exp", first_err_expected, e2);

      // Masking: masked lane ignored, fully masked beat never errors
      do_clear();
      send(pat(1) ^ 64'h0000_0000_0000_FF00, pat(1), 8'h02, 8'h00);
      send(pat(1) ^ 64'hFFFF_FFFF_FFFF_FFFF, pat(1), 8'hFF, 8'h00);
      send(pat(1) ^ 64'h0000_0000_0000_FF00, pat(1), 8'h00, 8'h02);
      send(pat(3) ^ 64'h0000_00FF_0000_FF00, pat(3), 8'h02, 8'h10);
      idle(4);
      check("mask_lanes",  64'(err_lane_mask), 64'h12);
      check("mask_bursts", 64'(burst_count), 64'd2);

      // Clear discards the in-flight beat and the beat presented with it
      @(negedge clk0);
      rd_data_valid = 1'b1; rd_data = ~pat(7); cmp_data = pat(7); cmp_mask = '0;
      @(negedge clk0);
      clr_err = 1'b1; rd_data = ~pat(8); cmp_data = pat(8);
      @(negedge clk0);
      clr_err = 1'b0; rd_data_valid = 1'b0;
      model_reset();
      idle(4);
      check_all_zero("clear");

      // Saturation: 65540 corrupted beats
      do_clear();
      for (int i = 0; i < 65540; i++) send(pat(i) ^ 64'h0000_0000_0000_00FF, pat(i), 8'h00, 8'h01);
      idle(4);
      check("sat_count",  64'(err_count), 64'hFFFF);
      check("sat_sticky", 64'(err_sticky), 64'd1);

      // Reset mid-burst: in-burst counter must restart
      do_clear();
      send(pat(0) ^ 64'h0000_0000_0000_00FF, pat(0), 8'h00, 8'h01);
      idle(4);
      @(negedge clk0);
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk0);
      rst = 1'b0;
      model_reset();
      send(pat(1), pat(1), 8'h00, 8'h00);
      send(pat(2), pat(2), 8'h00, 8'h00);
      idle(4);
      check("rst_bursts", 64'(burst_count), 64'd1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk0);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr2_rd_data_checker.md
# ddr2_rd_data_checker

Read-side counterpart of the backend test-pattern generator. It takes read data returned by the DDR2 controller's read-data path and compares it, byte lane by byte lane, against the expected pattern the generator presents with each valid read beat. It reports per-beat mismatches, sticky error status, saturating counters and a capture of the first failing beat. It sits beside the backend generator in the example design, driven by the same `bkend_rd_data_valid` qualifier.

## Interface
- `DQ_WIDTH`, 32, memory data width; one beat is `2*DQ_WIDTH` bits (rise+fall).
- `BEATS_PER_BURST`, 2, beats per read burst (BL4 on the double-width bus); must be a power of 2, at least 1.
- `clk0`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_data_valid`  in  1  read beat qualifier (same timing as `bkend_rd_data_valid`).
- `rd_data`  in  2*DQ_WIDTH  read data beat from controller.
- `cmp_data`  in  2*DQ_WIDTH  expected data, aligned with `rd_data_valid`.
- `cmp_mask`  in  2*DQ_WIDTH/8  per-lane ignore; 1 = lane excluded from compare.
- `clr_err`  in  1  synchronous clear of status, counters, captures and pipeline.
- `cmp_error`  out  1  one-cycle pulse, mismatch on a beat.
- `err_sticky`  out  1  high once any mismatch has occurred since reset/clear.
- `err_lane_mask`  out  2*DQ_WIDTH/8  sticky OR of failing lanes.
- `err_count`  out  16  failing beats, saturating at 16'hFFFF.
- `burst_count`  out  16  completed bursts checked, wraps at 16'hFFFF to 0.
- `first_err_beat`  out  16  beat index (0-based, since clear) of first failing beat.
- `first_err_actual`, `first_err_expected`  out  2*DQ_WIDTH  captured data of first failing beat.
- `chk_state`  out  2  00 IDLE, 01 RUN, 10 FAIL.

## Operation
- Stage 1 registers `rd_data`, `cmp_data`, `cmp_mask` and the valid flag every cycle.
- Stage 2 computes `lane_err[i]` = valid and not mask[i] and (byte i of data != byte i of expected). It registers `cmp_error` = OR(`lane_err`).
- Beat counter (16 bit) increments on every stage-1 valid and wraps. It is the index used for `first_err_beat`.
- The in-burst counter counts stage-1 valid beats modulo `BEATS_PER_BURST`. On the last beat of a burst, `burst_count` increments.
- On a failing beat:
  - `err_count` increments, holding at FFFF.
  - `err_lane_mask` |= `lane_err`.
  - `err_sticky` is set.
- Captures load only when `err_sticky` was 0 before the failing beat (first failure only).
- State machine:
  - IDLE -> RUN on the first stage-1 valid beat without a mismatch.
  - IDLE or RUN -> FAIL on any mismatch.
  - FAIL holds until `clr_err`.
  - `clr_err` takes any state to IDLE.
- `clr_err` clears all counters, captures, sticky flags and both pipeline stages.
  - A beat in flight at the time is discarded.
  - A beat presented together with `clr_err` is also discarded.
  - `clr_err` wins over a simultaneous mismatch.
- Fully masked beat: counted as a beat and toward bursts; never an error.
- Masked lanes never contribute to `err_lane_mask`.

## Timing
- Reset values: every output is 0, `chk_state` = IDLE, and all internal registers are 0.
- Latency: a beat sampled at edge N produces `cmp_error`, counters, captures and state update visible after edge N+2.
- Back-to-back valid beats are supported at one per cycle with no stalls. There is no backpressure.
- `rst` asserted mid-burst: all state clears immediately. The in-burst counter restarts, so the next valid beat is beat 0 of a new burst.
- `err_count` saturation: at FFFF, further errors leave it at FFFF. `err_sticky` and `cmp_error` still behave normally.
- `burst_count` wrap: FFFF -> 0 on the next completed burst, with no flag.

## Test plan
- **Clean run.** After reset, 8 valid beats with `rd_data` == `cmp_data`, mask 0.
  - `cmp_error` stays 0 and `burst_count` = 4.
  - `chk_state` = RUN from 2 cycles after the first beat.
- **Single error.** Beat index 5 has byte lane 3 flipped (`rd_data` bits [31:24] ^ 8'hFF).
  - `cmp_error` pulses once, 2 cycles after that beat.
  - `err_count` = 1, `err_lane_mask` = 8'h08, `first_err_beat` = 5, `chk_state` = FAIL.
  - Captures equal the beat-5 data.
- **First-error capture.** Errors on beats 2 (lane 0) and 6 (lane 7).
  - Captures and `first_err_beat` = 2 are unchanged by beat 6.
  - `err_lane_mask` = 8'h81 and `err_count` = 2.
- **Masking.** Lane 1 corrupted with `cmp_mask` = 8'h02 -> no error. Same beat with mask 0 -> error on lane 1.
- **Clear and saturation.**
  - `clr_err` asserted in the same cycle as a corrupted beat -> no error is reported, state is IDLE and all counters are 0.
  - 65540 consecutive corrupted beats -> `err_count` = FFFF.
- **Reset mid-burst.** `rst` pulsed after beat 1 of a burst.
  - All outputs read 0.
  - The next 2 beats complete one burst, giving `burst_count` = 1.
